// File: rtl/mul_div_unit_e.sv
// Iterative RV32M multiply/divide unit: one result bit per clock, stalls the
// front of the pipe via oBusy and returns the result with a one-cycle oValid.
module mul_div_unit_e #(
   parameter int WIDTH = 32
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iValid,
   input  logic [2:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iFlush,
   output logic             oBusy,
   output logic             oValid,
   output logic [WIDTH-1:0] oResult
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, nextState;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc, accNext, prodSigned;
   logic [WIDTH-1:0]   opB, aMag, bMag, quo, rem, finalRes;
   logic [2:0]         op;
   logic               negRes, negRem;
   logic               accept, divZero, lastIter;
   logic               aSigned, bSigned, aNeg, bNeg;
   logic [WIDTH:0]     addSum, remSh, diff;

   assign accept   = (state == IDLE) && iValid && !iFlush;
   assign divZero  = iOp[2] && (iB == '0);
   assign lastIter = (state == CALC) && (cnt == CNT_W'(WIDTH-1));

   assign oBusy  = (state != IDLE);
   assign oValid = (state == DONE) && !iFlush;

   // Operand signedness: MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2.
   always_comb begin
      aSigned = (iOp == 3'b001) || (iOp == 3'b010) || (iOp == 3'b100) || (iOp == 3'b110);
      bSigned = (iOp == 3'b001) || (iOp == 3'b100) || (iOp == 3'b110);
      aNeg    = aSigned && iA[WIDTH-1];
      bNeg    = bSigned && iB[WIDTH-1];
      aMag    = aNeg ? -iA : iA;
      bMag    = bNeg ? -iB : iB;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = divZero ? DONE : CALC;
         CALC:    if (iFlush) nextState = IDLE;
                  else if (lastIter) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // acc = {upper, lower}: multiply shifts the multiplier out of the lower half while
   // the partial product grows in; divide shifts dividend bits into the remainder.
   always_comb begin
      addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
      remSh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = remSh - {1'b0, opB};
      if (op[2])
         accNext = diff[WIDTH] ? {remSh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
      else
         accNext = {addSum, acc[WIDTH-1:1]};
      prodSigned = negRes ? -accNext : accNext;
      quo        = accNext[WIDTH-1:0];
      rem        = accNext[2*WIDTH-1:WIDTH];
      case (op)
         3'b000:                 finalRes = prodSigned[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: finalRes = prodSigned[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         finalRes = negRes ? -quo : quo;
         default:                finalRes = negRem ? -rem : rem;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cnt     <= '0;
         acc     <= '0;
         opB     <= '0;
         op      <= '0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         oResult <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op     <= iOp;
               opB    <= bMag;
               acc    <= {{WIDTH{1'b0}}, aMag};
               cnt    <= '0;
               negRes <= aNeg ^ bNeg;
               negRem <= aNeg;
               if (divZero) oResult <= iOp[1] ? iA : '1;
            end
            CALC: if (!iFlush) begin
               acc <= accNext;
               cnt <= cnt + CNT_W'(1);
               if (lastIter) oResult <= finalRes;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit_e.sv
// Self-checking bench for mul_div_unit_e: directed vectors, flush/reset sequences,
// and randomized ops against a 64-bit arithmetic reference.
module tb_mul_div_unit_e;

   logic        iClk = 1'b0;
   logic        iRst;
   logic        iValid;
   logic [2:0]  iOp;
   logic [31:0] iA, iB;
   logic        iFlush;
   logic        oBusy, oValid;
   logic [31:0] oResult;

   int checks = 0;
   int errors = 0;

   mul_div_unit_e #(.WIDTH(32)) dut (
      .iClk(iClk), .iRst(iRst), .iValid(iValid), .iOp(iOp), .iA(iA), .iB(iB),
      .iFlush(iFlush), .oBusy(oBusy), .oValid(oValid), .oResult(oResult)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   // Issue one op and count edges (accept edge = 1) until oValid; lat=0 on timeout.
   task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy1);
      lat   = 0;
      busy1 = 1'b0;
      res   = 'x;
      @(negedge iClk);
      iValid = 1'b1; iOp = op; iA = a; iB = b;
      @(posedge iClk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge iClk);
         if (k == 1) begin
            iValid = 1'b0;
            busy1  = oBusy;
         end
         if (oValid) begin
            lat = k;
            res = oResult;
            break;
         end
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] res, exp;
      logic        busy1;
      int          lat, pulses;

      vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33};
      vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 33};
      vecs[2]  = '{3'd3, 32'hFFFFFFFD, 32'd7,        32'h00000006, 33};
      vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
      vecs[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
      vecs[5]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
      vecs[6]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
      vecs[7]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[8]  = '{3'd6, 32'h80000000, 32'd0,        32'h80000000, 1};
      vecs[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
      vecs[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
      vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      vecs[12] = '{3'd4, 32'd0,        32'd0,        32'hFFFFFFFF, 1};

      iRst = 1'b1; iValid = 1'b0; iOp = '0; iA = '0; iB = '0; iFlush = 1'b0;
      #12;
      chk("rst_busy",   {31'b0, oBusy},  32'd0);
      chk("rst_valid",  {31'b0, oValid}, 32'd0);
      chk("rst_result", oResult,         32'd0);
      @(negedge iClk);
      iRst = 1'b0;

      foreach (vecs[i]) begin
         runOp(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy1);
         chk($sformatf("vec%0d_res", i), res, vecs[i].exp);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy", i), {31'b0, busy1}, 32'd1);
      end

      // Flush at iteration 10: no result, oResult keeps the previous value.
      runOp(3'd5, 32'd100, 32'd7, res, lat, busy1);
      @(negedge iClk);
      iValid = 1'b1; iOp = 3'd0; iA = 32'd3; iB = 32'd5;
      @(posedge iClk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge iClk);
         iValid = 1'b0;
      end
      iFlush = 1'b1;
      @(negedge iClk);
      iFlush = 1'b0;
      chk("flush_busy", {31'b0, oBusy}, 32'd0);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge iClk);
         if (oValid) pulses++;
      end
      chk("flush_novalid", pulses, 32'd0);
      chk("flush_keep",    oResult, 32'd14);

      // iValid and iFlush together in IDLE: not accepted.
      @(negedge iClk);
      iValid = 1'b1; iFlush = 1'b1; iOp = 3'd3; iA = 32'd9; iB = 32'd9;
      @(negedge iClk);
      chk("vflush_busy", {31'b0, oBusy}, 32'd0);
      iValid = 1'b0; iFlush = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge iClk);
         if (oValid) pulses++;
      end
      chk("vflush_novalid", pulses, 32'd0);

      // iValid held through CALC: exactly one result.
      @(negedge iClk);
      iValid = 1'b1; iOp = 3'd7; iA = 32'd100; iB = 32'd7;
      pulses = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge iClk);
         if (oValid) begin
            pulses++;
            res    = oResult;
            iValid = 1'b0;
         end
      end
      chk("hold_pulses", pulses, 32'd1);
      chk("hold_res",    res,    32'd2);

      // Async reset between edges mid-CALC.
      @(negedge iClk);
      iValid = 1'b1; iOp = 3'd1; iA = 32'hDEADBEEF; iB = 32'h12345678;
      @(posedge iClk);
      for (int k = 0; k < 5; k++) begin
         @(negedge iClk);
         iValid = 1'b0;
      end
      #2 iRst = 1'b1;
      #1;
      chk("arst_busy",   {31'b0, oBusy},  32'd0);
      chk("arst_valid",  {31'b0, oValid}, 32'd0);
      chk("arst_result", oResult,         32'd0);
      @(negedge iClk);
      iRst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge iClk);
         if (oValid) pulses++;
      end
      chk("arst_novalid", pulses, 32'd0);

      // Randomized ops against the arithmetic reference.
      for (int n = 0; n < 1500; n++) begin
         logic [2:0]  rop;
         logic [31:0] ra, rb;
         int          elat;
         rop  = 3'($urandom_range(0, 7));
         ra   = pickOperand();
         rb   = pickOperand();
         exp  = refModel(rop, ra, rb);
         elat = (rop[2] && rb == 0) ? 1 : 33;
         runOp(rop, ra, rb, res, lat, busy1);
         chk($sformatf("rnd%0d_op%0d_%h_%h", n, rop, ra, rb), res, exp);
         chk($sformatf("rnd%0d_lat", n), lat, elat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
